// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory: byte/half/word stores and loads, 1-cycle registered read,
// alignment/range fault pulses and an optional post-reset clearing sweep.
module data_memory_bytelane #(
   parameter int unsigned DEPTH          = 512,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data_in,
   input  logic        i_mem_wr,
   input  logic        i_mem_rd,
   input  logic [1:0]  i_size,
   input  logic        i_sign_ext,
   output logic [31:0] o_data_out,
   output logic        o_rd_valid,
   output logic        o_busy,
   output logic        o_misalign,
   output logic        o_out_of_range
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {StInit, StReady} state_e;

   state_e      r_state;
   logic [AW-1:0] r_cnt;
   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_data_out;
   logic        r_rd_valid;
   logic        r_misalign;
   logic        r_out_of_range;

   logic [AW-1:0] w_idx;
   logic          w_misalign;
   logic          w_out_of_range;
   logic          w_fault;
   logic          w_wr_ok;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;

   assign w_idx          = i_addr[AW+1:2];
   assign w_out_of_range = (i_addr[31:2] >= 30'(DEPTH));
   assign w_fault        = w_misalign | w_out_of_range;
   assign w_wr_ok        = (r_state == StReady) & i_mem_wr & ~w_fault;

   always_comb begin
      w_misalign = 1'b0;
      unique case (i_size)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = i_addr[0];
         2'b10:   w_misalign = (i_addr[1:0] != 2'b00);
         default: w_misalign = 1'b1;
      endcase
   end

   // Load path reads pre-edge contents, which gives read-before-write on a shared word.
   always_comb begin
      w_word = r_mem[w_idx];
      w_byte = w_word[{i_addr[1:0], 3'b000} +: 8];
      w_half = i_addr[1] ? w_word[31:16] : w_word[15:0];
      w_load = w_word;
      unique case (i_size)
         2'b00:   w_load = {{24{i_sign_ext & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{i_sign_ext & w_half[15]}}, w_half};
         default: w_load = w_word;
      endcase
   end

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_data_in;
      unique case (i_size)
         2'b00: begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_data_in[7:0]}};
         end
         2'b01: begin
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_data_in[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_data_in;
         end
      endcase
   end

   // Storage has no reset; the sweep is what zeroes it.
   always_ff @(posedge i_clk) begin
      if (r_state == StInit) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state        <= CLEAR_ON_RESET ? StInit : StReady;
         r_cnt          <= '0;
         r_data_out     <= '0;
         r_rd_valid     <= 1'b0;
         r_misalign     <= 1'b0;
         r_out_of_range <= 1'b0;
      end else begin
         r_rd_valid     <= 1'b0;
         r_misalign     <= 1'b0;
         r_out_of_range <= 1'b0;
         if (r_state == StInit) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == AW'(DEPTH - 1)) r_state <= StReady;
         end else begin
            if (i_mem_rd | i_mem_wr) begin
               r_misalign     <= w_misalign;
               r_out_of_range <= w_out_of_range;
            end
            if (i_mem_rd) begin
               r_rd_valid <= 1'b1;
               r_data_out <= w_fault ? '0 : w_load;
            end
         end
      end
   end

   assign o_data_out     = r_data_out;
   assign o_rd_valid     = r_rd_valid;
   assign o_busy         = (r_state == StInit);
   assign o_misalign     = r_misalign;
   assign o_out_of_range = r_out_of_range;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane (DEPTH=16): directed scenarios plus randomized traffic
// checked against an arithmetic word-array model.
module tb_data_memory_bytelane;

   localparam int unsigned DEPTH = 16;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic        mem_wr;
   logic        mem_rd;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] data_out;
   logic        rd_valid;
   logic        busy;
   logic        misalign;
   logic        out_of_range;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] model [DEPTH];
   logic [31:0] exp_dout;

   data_memory_bytelane #(
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_addr         (addr),
      .i_data_in      (data_in),
      .i_mem_wr       (mem_wr),
      .i_mem_rd       (mem_rd),
      .i_size         (size),
      .i_sign_ext     (sign_ext),
      .o_data_out     (data_out),
      .o_rd_valid     (rd_valid),
      .o_busy         (busy),
      .o_misalign     (misalign),
      .o_out_of_range (out_of_range)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0) || (sz == 2'd3);
   endfunction

   function automatic logic ref_oor(input logic [31:0] a);
      return (a / 4) >= DEPTH;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sx);
      logic [31:0] word;
      logic [31:0] v;
      int unsigned sh;
      word = model[a[5:2]];
      sh   = (a % 4) * 8;
      case (sz)
         2'd0: begin
            v = (word >> sh) % 256;
            if (sx && v >= 128) v = v + 32'hFFFF_FF00;
         end
         2'd1: begin
            v = (word >> sh) % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF_0000;
         end
         default: v = word;
      endcase
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] word;
      logic [31:0] mask;
      int unsigned sh;
      word = model[a[5:2]];
      sh   = (a % 4) * 8;
      case (sz)
         2'd0: begin
            mask = 32'h0000_00FF << sh;
            model[a[5:2]] = (word & ~mask) | ((d & 32'h0000_00FF) << sh);
         end
         2'd1: begin
            mask = 32'h0000_FFFF << sh;
            model[a[5:2]] = (word & ~mask) | ((d & 32'h0000_FFFF) << sh);
         end
         default: model[a[5:2]] = d;
      endcase
   endtask

   // One request cycle in READY; outputs are sampled 1 time unit after the edge.
   task automatic op(input logic wr, input logic rd, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] d);
      mem_wr   = wr;
      mem_rd   = rd;
      size     = sz;
      sign_ext = sx;
      addr     = a;
      data_in  = d;
      @(posedge clk);
      #1;
      mem_wr = 1'b0;
      mem_rd = 1'b0;
      if (wr && !ref_mis(sz, a) && !ref_oor(a)) ref_store(a, sz, d);
   endtask

   task automatic release_and_count(input string tag);
      int n;
      @(negedge clk);
      rst = 1'b1;
      n   = 0;
      while (busy && n < 4 * DEPTH) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (n !== DEPTH) $display("FAIL %s sweep length: got %0d cycles, expected %0d", tag, n, DEPTH);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      exp_dout = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({data_out, rd_valid, misalign, out_of_range} !== 35'd0)
         $display("FAIL reset outputs: got %h/%b/%b/%b, expected 0", data_out, rd_valid, misalign,
                  out_of_range);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL reset busy: got %b, expected 1", busy);
      else n_pass++;
      #20;
      release_and_count("initial");
   endtask

   task automatic test_clear_sweep;
      int n;
      for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 2'd2, 1'b0, 32'(4 * i), $urandom);
      @(negedge clk);
      rst = 1'b0;
      #3;
      @(negedge clk);
      rst = 1'b1;
      // Keep requesting a write to word 1 and a load for the whole sweep.
      mem_wr  = 1'b1;
      mem_rd  = 1'b1;
      size    = 2'd2;
      addr    = 32'h4;
      data_in = 32'hFFFF_FFFF;
      n = 0;
      while (busy && n < 4 * DEPTH) begin
         @(posedge clk);
         #1;
         n++;
         n_checks++;
         if (rd_valid !== 1'b0 || misalign !== 1'b0)
            $display("FAIL busy ignores rd: got rd_valid=%b misalign=%b, expected 0", rd_valid,
                     misalign);
         else n_pass++;
      end
      mem_wr = 1'b0;
      mem_rd = 1'b0;
      n_checks++;
      if (n !== DEPTH) $display("FAIL clear sweep length: got %0d, expected %0d", n, DEPTH);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         op(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * i), 32'd0);
         n_checks++;
         if (data_out !== 32'd0 || rd_valid !== 1'b1)
            $display("FAIL cleared word %0d: got %h valid %b, expected 0 valid 1", i, data_out,
                     rd_valid);
         else n_pass++;
      end
      exp_dout = '0;
   endtask

   task automatic test_byte;
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h1122_3344);
      op(1'b1, 1'b0, 2'd0, 1'b0, 32'h9, 32'h0000_00AB);
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h8, 32'd0);
      n_checks++;
      if (data_out !== 32'h1122_AB44) $display("FAIL sb merge: got %h, expected 1122ab44", data_out);
      else n_pass++;
      op(1'b0, 1'b1, 2'd0, 1'b1, 32'h9, 32'd0);
      n_checks++;
      if (data_out !== 32'hFFFF_FFAB) $display("FAIL lb signed: got %h, expected ffffffab", data_out);
      else n_pass++;
      op(1'b0, 1'b1, 2'd0, 1'b0, 32'h9, 32'd0);
      n_checks++;
      if (data_out !== 32'h0000_00AB) $display("FAIL lbu: got %h, expected 000000ab", data_out);
      else n_pass++;
   endtask

   task automatic test_half;
      op(1'b1, 1'b0, 2'd1, 1'b0, 32'hE, 32'h0000_8001);
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'hC, 32'd0);
      n_checks++;
      if (data_out !== 32'h8001_0000) $display("FAIL sh upper: got %h, expected 80010000", data_out);
      else n_pass++;
      op(1'b0, 1'b1, 2'd1, 1'b1, 32'hE, 32'd0);
      n_checks++;
      if (data_out !== 32'hFFFF_8001) $display("FAIL lh signed: got %h, expected ffff8001", data_out);
      else n_pass++;
      op(1'b0, 1'b1, 2'd1, 1'b0, 32'hE, 32'd0);
      n_checks++;
      if (data_out !== 32'h0000_8001) $display("FAIL lhu: got %h, expected 00008001", data_out);
      else n_pass++;
   endtask

   task automatic test_faults;
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'hCAFE_F00D);
      op(1'b1, 1'b0, 2'd1, 1'b0, 32'h5, 32'h0000_1234);
      n_checks++;
      if ({misalign, out_of_range, rd_valid} !== 3'b100)
         $display("FAIL sh misaligned flags: got %b%b%b, expected 100", misalign, out_of_range,
                  rd_valid);
      else n_pass++;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h4, 32'd0);
      n_checks++;
      if (data_out !== 32'hCAFE_F00D || misalign !== 1'b0)
         $display("FAIL faulted store wrote: got %h mis %b, expected cafef00d mis 0", data_out,
                  misalign);
      else n_pass++;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h6, 32'd0);
      n_checks++;
      if ({data_out, rd_valid, misalign, out_of_range} !== {32'd0, 3'b110})
         $display("FAIL lw misaligned: got %h/%b/%b/%b, expected 0/1/1/0", data_out, rd_valid,
                  misalign, out_of_range);
      else n_pass++;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'd0);
      n_checks++;
      if ({data_out, rd_valid, misalign, out_of_range} !== {32'd0, 3'b101})
         $display("FAIL lw out of range: got %h/%b/%b/%b, expected 0/1/0/1", data_out, rd_valid,
                  misalign, out_of_range);
      else n_pass++;
      op(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'd0);
      n_checks++;
      if (misalign !== 1'b1) $display("FAIL size 11: got misalign %b, expected 1", misalign);
      else n_pass++;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * DEPTH + 1), 32'd0);
      n_checks++;
      if ({misalign, out_of_range} !== 2'b11)
         $display("FAIL both flags: got %b%b, expected 11", misalign, out_of_range);
      else n_pass++;
      // An out-of-range store must not alias onto a low word.
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'(4 * DEPTH + 8), 32'h5555_5555);
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h8, 32'd0);
      n_checks++;
      if (data_out !== 32'h1122_AB44) $display("FAIL oor store alias: got %h, expected 1122ab44",
                                               data_out);
      else n_pass++;
      exp_dout = data_out;
   endtask

   task automatic test_rbw;
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
      op(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678);
      n_checks++;
      if (data_out !== 32'hDEAD_BEEF) $display("FAIL read-before-write: got %h, expected deadbeef",
                                               data_out);
      else n_pass++;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'd0);
      n_checks++;
      if (data_out !== 32'h1234_5678) $display("FAIL store after rbw: got %h, expected 12345678",
                                               data_out);
      else n_pass++;
      exp_dout = data_out;
   endtask

   task automatic test_random;
      logic        wr, rd, sx, flt, e_mis, e_oor;
      logic [1:0]  sz;
      logic [31:0] a, d;
      for (int i = 0; i < 200; i++) begin
         wr = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         sx = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = ($urandom_range(0, 7) == 0) ? 32'(4 * DEPTH) + ($urandom % 4096)
                                          : 32'($urandom_range(0, 4 * DEPTH - 1));
         d  = $urandom;
         e_mis = (wr || rd) && ref_mis(sz, a);
         e_oor = (wr || rd) && ref_oor(a);
         flt   = ref_mis(sz, a) || ref_oor(a);
         if (rd) exp_dout = flt ? 32'd0 : ref_load(a, sz, sx);
         op(wr, rd, sz, sx, a, d);
         n_checks++;
         if (data_out !== exp_dout || rd_valid !== rd)
            $display("FAIL random load %0d: got %h valid %b, expected %h valid %b", i, data_out,
                     rd_valid, exp_dout, rd);
         else n_pass++;
         n_checks++;
         if ({misalign, out_of_range} !== {e_mis, e_oor})
            $display("FAIL random flags %0d: got %b%b, expected %b%b", i, misalign, out_of_range,
                     e_mis, e_oor);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_access;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h6, 32'd0);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({data_out, rd_valid, misalign, out_of_range, busy} !== {32'd0, 4'b0001})
         $display("FAIL async reset mid-access: got %h/%b/%b/%b/%b, expected 0/0/0/0/1",
                  data_out, rd_valid, misalign, out_of_range, busy);
      else n_pass++;
      release_and_count("mid-access");
   endtask

   task automatic test_reset_mid_sweep;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      n_checks++;
      if ({data_out, rd_valid, misalign, out_of_range, busy} !== {32'd0, 4'b0001})
         $display("FAIL async reset mid-sweep: got %h/%b/%b/%b/%b, expected 0/0/0/0/1",
                  data_out, rd_valid, misalign, out_of_range, busy);
      else n_pass++;
      release_and_count("mid-sweep");
      for (int i = 0; i < DEPTH; i += 5) begin
         op(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * i), 32'd0);
         n_checks++;
         if (data_out !== 32'd0) $display("FAIL resweep word %0d: got %h, expected 0", i, data_out);
         else n_pass++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      addr     = '0;
      data_in  = '0;
      mem_wr   = 1'b0;
      mem_rd   = 1'b0;
      size     = 2'd2;
      sign_ext = 1'b0;
      exp_dout = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      test_reset;
      test_clear_sweep;
      test_byte;
      test_half;
      test_faults;
      test_rbw;
      test_random;
      test_reset_mid_access;
      test_reset_mid_sweep;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
